// File: rtl/pwm_bank_multi.sv
// Multi-channel PWM generator: NUM_CH duty channels share one prescaler and period
// counter, with edge/centre alignment and shadowed config loaded at period boundaries.
module pwm_bank_multi #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic [CNT_W-1:0]  cnt_out
);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_CTRL  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESC = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP   = ADDR_W'(2);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    logic              en_q;
    logic              mode_w_q;
    logic              mode_a_q;
    logic [CNT_W-1:0]  presc_w_q;
    logic [CNT_W-1:0]  presc_a_q;
    logic [CNT_W-1:0]  top_w_q;
    logic [CNT_W-1:0]  top_a_q;
    logic [CNT_W-1:0]  pre_cnt_q;
    logic [CNT_W-1:0]  pre_cnt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              dir_q;
    logic              dir_d;
    logic              tick;
    logic              boundary;
    logic              load_shadow;
    logic [NUM_CH-1:0] pwm_q;
    logic [NUM_CH-1:0] pwm_d;
    logic              period_tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            mode_w_q  <= 1'b0;
            presc_w_q <= '0;
            top_w_q   <= '1;
        end else if (cfg_we) begin
            if (cfg_addr == ADDR_CTRL) begin
                en_q     <= cfg_wdata[0];
                mode_w_q <= cfg_wdata[1];
            end
            if (cfg_addr == ADDR_PRESC) presc_w_q <= cfg_wdata;
            if (cfg_addr == ADDR_TOP)   top_w_q   <= cfg_wdata;
        end
    end

    // Shadows take the pre-write copy, so a write on a boundary edge waits one period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_a_q  <= 1'b0;
            presc_a_q <= '0;
            top_a_q   <= '1;
        end else if (load_shadow) begin
            mode_a_q  <= mode_w_q;
            presc_a_q <= presc_w_q;
            top_a_q   <= top_w_q;
        end
    end

    always_comb begin
        tick        = en_q && (pre_cnt_q >= presc_a_q);
        boundary    = 1'b0;
        pre_cnt_d   = '0;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        if (!en_q) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_ONE;
            if (tick) begin
                if (!mode_a_q) begin
                    dir_d = DIR_UP;
                    if (cnt_q >= top_a_q) begin
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (top_a_q == '0) begin
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end else if (dir_q == DIR_UP && cnt_q < top_a_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q <= CNT_ONE) begin
                    // Descending 1 -> 0 closes the centre-aligned period.
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    dir_d = DIR_DOWN;
                end
            end
        end
        load_shadow = !en_q || boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            dir_q         <= DIR_UP;
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            pwm_q         <= pwm_d;
            period_tick_q <= boundary;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [ADDR_W-1:0] ADDR_DUTY = ADDR_W'(gi + 3);
            logic [CNT_W-1:0] duty_w_q;
            logic [CNT_W-1:0] duty_a_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_w_q <= '0;
                    duty_a_q <= '0;
                end else begin
                    if (cfg_we && cfg_addr == ADDR_DUTY) duty_w_q <= cfg_wdata;
                    if (load_shadow) duty_a_q <= duty_w_q;
                end
            end

            assign pwm_d[gi] = en_q && (cnt_q < duty_a_q);
        end
    endgenerate

    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;
    assign cnt_out     = cnt_q;
endmodule

// File: tb/tb_pwm_bank_multi.sv
// Directed + random bench for pwm_bank_multi; the reference model tracks the
// position inside the current period and derives cnt/pwm/tick arithmetically.
module tb_pwm_bank_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CNT_W-1:0]  cfg_wdata = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;
    logic [CNT_W-1:0]  cnt_out;

    pwm_bank_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .pwm_out(pwm_out), .period_tick(period_tick),
        .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int hi0_acc  = 0;
    int tick_acc = 0;

    // Reference model: written config, active config, clocks elapsed in period.
    bit m_en, m_mode_w, m_mode_a;
    int m_p_w, m_p_a, m_top_w, m_top_a;
    int m_d_w [NUM_CH];
    int m_d_a [NUM_CH];
    int m_t;
    int exp_cnt;
    bit exp_tick;
    logic [NUM_CH-1:0] exp_pwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int period_len();
        if (!m_mode_a) return (m_top_a + 1) * (m_p_a + 1);
        if (m_top_a == 0) return m_p_a + 1;
        return 2 * m_top_a * (m_p_a + 1);
    endfunction

    function automatic int cnt_at(input int t);
        int k;
        k = t / (m_p_a + 1);
        if (!m_mode_a) return k;
        if (m_top_a == 0) return 0;
        return (k <= m_top_a) ? k : 2 * m_top_a - k;
    endfunction

    task automatic load_active();
        m_mode_a = m_mode_w;
        m_p_a    = m_p_w;
        m_top_a  = m_top_w;
        for (int i = 0; i < NUM_CH; i++) m_d_a[i] = m_d_w[i];
    endtask

    task automatic model_reset();
        m_en = 0; m_mode_w = 0; m_p_w = 0; m_top_w = 255;
        for (int i = 0; i < NUM_CH; i++) m_d_w[i] = 0;
        load_active();
        m_t = 0; exp_cnt = 0; exp_tick = 0; exp_pwm = '0;
    endtask

    task automatic model_edge(input bit r, input bit we, input int addr, input int data);
        if (r) begin
            model_reset();
        end else begin
            if (m_en) begin
                for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = (exp_cnt < m_d_a[i]);
                m_t++;
                if (m_t >= period_len()) begin
                    m_t = 0;
                    exp_tick = 1;
                    load_active();
                end else begin
                    exp_tick = 0;
                end
                exp_cnt = cnt_at(m_t);
            end else begin
                exp_pwm = '0; exp_tick = 0; m_t = 0; exp_cnt = 0;
                load_active();
            end
            if (we) begin
                if (addr == 0) begin
                    m_en     = (data & 1) != 0;
                    m_mode_w = (data & 2) != 0;
                end else if (addr == 1) m_p_w = data;
                else if (addr == 2) m_top_w = data;
                else if (addr >= 3 && addr < 3 + NUM_CH) m_d_w[addr - 3] = data;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit we, input int addr, input int data);
        rst = r;
        cfg_we = we;
        cfg_addr = ADDR_W'(addr);
        cfg_wdata = CNT_W'(data);
        @(posedge clk);
        model_edge(r, we, addr, data);
        @(negedge clk);
        check("cnt_out", 32'(cnt_out), exp_cnt);
        check("period_tick", 32'(period_tick), 32'(exp_tick));
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        hi0_acc += int'(pwm_out[0]);
        tick_acc += int'(period_tick);
    endtask

    task automatic wr(input int addr, input int data);
        cycle(0, 1, addr, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic window(input int n);
        hi0_acc = 0;
        tick_acc = 0;
        idle(n);
    endtask

    // kind 0: period_tick, 1: cnt_out == val, 2: pwm_out[0] high
    task automatic wait_for(input string tag, input int kind, input int val, input int limit);
        bit found;
        found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            idle(1);
            if (kind == 0 && period_tick === 1'b1) found = 1;
            if (kind == 1 && cnt_out === CNT_W'(val)) found = 1;
            if (kind == 2 && pwm_out[0] === 1'b1) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            cycle(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 255));
        idle(4);

        // Edge basic
        wr(1, 0); wr(2, 9); wr(3, 3); wr(4, 10); wr(5, 0); wr(6, $urandom_range(0, 20));
        wr(0, 1);
        wait_for("edge_first_tick", 0, 0, 40);
        window(10);
        check("edge_hi0", hi0_acc, 3);
        check("edge_ticks", tick_acc, 1);

        // Shadowed duty update mid-period
        wait_for("shadow_cnt5", 1, 5, 40);
        wr(3, 7);
        wait_for("shadow_tick", 0, 0, 20);
        window(10);
        check("shadow_hi0", hi0_acc, 7);

        // Centre mode
        wr(2, 4); wr(3, 2); wr(0, 3);
        wait_for("centre_tick", 0, 0, 40);
        window(8);
        check("centre_hi0", hi0_acc, 3);
        check("centre_ticks", tick_acc, 1);
        window(8);
        check("centre_ticks2", tick_acc, 1);

        // Prescale, then a write landing exactly on the boundary edge
        wr(1, 2); wr(2, 9); wr(0, 1);
        wait_for("pre_tick", 0, 0, 100);
        window(30);
        check("pre_hi0", hi0_acc, 6);
        check("pre_ticks", tick_acc, 1);
        idle(29);
        wr(3, 5);
        check("pre_boundary_tick", 32'(period_tick), 32'd1);
        window(30);
        check("pre_hold_hi0", hi0_acc, 6);
        window(30);
        check("pre_new_hi0", hi0_acc, 15);

        // Mid-run reset with a simultaneous write, then re-enable from reset config
        wr(1, 0);
        wait_for("rst_pwm0_high", 2, 0, 200);
        cycle(1, 1, 2, 5);
        idle(2);
        wr(0, 1);
        idle(20);
        wr(0, 0);
        idle(2);

        // Random configuration traffic
        for (int i = 0; i < 400; i++) begin
            int addr, data;
            if ($urandom_range(0, 99) == 0) begin
                cycle(1, 0, 0, 0);
            end else if ($urandom_range(0, 3) == 0) begin
                addr = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 9);
                case (addr)
                    0: data = $urandom_range(0, 255) | ($urandom_range(0, 3) != 0 ? 1 : 0);
                    1: data = $urandom_range(0, 3);
                    2: data = $urandom_range(0, 12);
                    3, 4, 5, 6: data = $urandom_range(0, 15);
                    default: data = $urandom_range(0, 255);
                endcase
                wr(addr, data);
            end else begin
                idle(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
